word_serializer: RTL

WORD_SERIALIZER -- requirements
Module: word_serializer

---
 rtl/word_serializer.sv | 68 ++++++
 1 files changed

// File: rtl/word_serializer.sv
// rtl/word_serializer.sv - splits a WORD_W-bit word into NLANES lanes of LANE_W bits
// Optional macro WORD_SERIALIZER_PARITY_EN adds a lane_parity output (XOR of lane_data).
module word_serializer #(
  parameter int WORD_W    = 32,
  parameter int LANE_W    = 8,
  parameter int MSB_FIRST = 0,
  localparam int NLANES   = WORD_W / LANE_W,
  localparam int IDX_W    = (NLANES > 1) ? $clog2(NLANES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              lane_valid,
  output logic [LANE_W-1:0] lane_data,
  input  logic              lane_ready,
  output logic              lane_last,
  output logic [IDX_W-1:0]  lane_idx
`ifdef WORD_SERIALIZER_PARITY_EN
  ,
  output logic              lane_parity
`endif
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state;
  logic [WORD_W-1:0] sreg;
  logic              word_hs;
  logic              lane_hs;

  assign lane_valid = (state == SHIFT);
  assign lane_last  = lane_valid && (lane_idx == IDX_W'(NLANES - 1));
  // Accepting during the final lane handshake lets words stream with no bubble.
  assign word_ready = !rst && ((state == IDLE) || (lane_last && lane_ready));
  assign word_hs    = word_valid && word_ready;
  assign lane_hs    = lane_valid && lane_ready;

  // The register is cleared whenever no word is held, so lane_data reads 0 in IDLE.
  assign lane_data = (MSB_FIRST != 0) ? sreg[WORD_W-1 -: LANE_W] : sreg[LANE_W-1:0];

`ifdef WORD_SERIALIZER_PARITY_EN
  assign lane_parity = ^lane_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lane_idx <= '0;
      sreg     <= '0;
    end else if (word_hs) begin
      state    <= SHIFT;
      sreg     <= word_data;
      lane_idx <= '0;
    end else if (lane_hs) begin
      if (lane_last) begin
        state    <= IDLE;
        sreg     <= '0;
        lane_idx <= '0;
      end else begin
        lane_idx <= lane_idx + IDX_W'(1);
        sreg     <= (MSB_FIRST != 0) ? (sreg << LANE_W) : (sreg >> LANE_W);
      end
    end
  end

endmodule
